pc_gen: RTL and testbench

- Parametrised program-counter generator for the RISC-V fetch stage. Successor to the single-width PC register.
- Adds:
  - configurable XLEN and reset vector
  - post-reset boot delay
  - halt/resume state machine
  - trap redirect with priority over branch redirect
  - fetch handshake with instruction memory
  - misaligned-target flagging
- Sits between Hazard Detection / Control Unit / ALU and Instruction Mem.

---
 rtl/pc_gen.sv | 154 +++++++++++++++
 tb/tb_pc_gen.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage.
// Boot delay, halt/resume FSM, trap/redirect steering, fetch handshake with
// instruction memory and misaligned-target flagging.
// Optional branch target buffer: define PC_BTB_EN to build it.
module pc_gen #(
  parameter int unsigned XLEN                    = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR        = '0,
  parameter int unsigned BOOT_DELAY              = 4,
  parameter int unsigned BTB_DEPTH               = 8  // power of two, >= 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            imem_ready,
  input  logic            btb_upd,
  input  logic [XLEN-1:0] btb_src_pc,
  input  logic [XLEN-1:0] btb_tgt,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned,
  output logic            pred_taken,
  output logic [1:0]      state_o
);

  localparam int unsigned CntW = (BOOT_DELAY > 0) ? $clog2(BOOT_DELAY + 1) : 1;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [CntW-1:0] cnt_q;
  logic            misaligned_q;
  logic            pred_q;

  logic            accept;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] redir_pc;
  logic            btb_hit;
  logic [XLEN-1:0] btb_next;

  assign pc_out     = pc_q;
  assign pc_plus4   = pc_q + XLEN'(4);
  assign pc_valid   = (state_q == StRun);
  assign accept     = pc_valid & imem_ready & ~stall;
  assign trap_pc    = {trap_vec[XLEN-1:2], 2'b00};
  assign redir_pc   = {redirect_pc[XLEN-1:2], 2'b00};
  assign misaligned = misaligned_q;
  assign pred_taken = pred_q;
  assign state_o    = state_q;

`ifdef PC_BTB_EN
  localparam int unsigned IdxW = $clog2(BTB_DEPTH);
  localparam int unsigned TagW = XLEN - IdxW - 2;

  logic [BTB_DEPTH-1:0] btb_valid_q;
  logic [TagW-1:0]      btb_tag_q [BTB_DEPTH];
  logic [XLEN-1:0]      btb_tgt_q [BTB_DEPTH];
  logic [IdxW-1:0]      lk_idx;
  logic [IdxW-1:0]      wr_idx;
  logic                 unused_btb;

  assign lk_idx     = pc_q[IdxW+1:2];
  assign wr_idx     = btb_src_pc[IdxW+1:2];
  // Lookup reads registered state, so a same-cycle write lands only afterwards.
  assign btb_hit    = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == pc_q[XLEN-1:IdxW+2]);
  assign btb_next   = btb_tgt_q[lk_idx];
  assign unused_btb = ^{btb_src_pc[1:0], btb_tgt[1:0]};

  // Valid bits are the only BTB state that needs clearing on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btb_valid_q <= '0;
    end else if (btb_upd) begin
      btb_valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and target payload, written alongside the valid bit.
  always_ff @(posedge clk) begin
    if (btb_upd) begin
      btb_tag_q[wr_idx] <= btb_src_pc[XLEN-1:IdxW+2];
      btb_tgt_q[wr_idx] <= {btb_tgt[XLEN-1:2], 2'b00};
    end
  end
`else
  logic unused_btb;

  assign btb_hit    = 1'b0;
  assign btb_next   = '0;
  assign unused_btb = ^{btb_upd, btb_src_pc, btb_tgt};
`endif

  // FSM plus all registered outputs: state, pc, boot counter, flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StBoot;
      pc_q         <= RESET_VECTOR;
      cnt_q        <= CntW'(BOOT_DELAY);
      misaligned_q <= 1'b0;
      pred_q       <= 1'b0;
    end else begin
      misaligned_q <= 1'b0;
      unique case (state_q)
        StBoot: begin
          if (cnt_q == '0) begin
            state_q <= StRun;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StRun: begin
          // Trap and redirect flush regardless of stall or imem_ready.
          if (trap) begin
            pc_q         <= trap_pc;
            misaligned_q <= (trap_vec[1:0] != 2'b00);
            pred_q       <= 1'b0;
          end else if (redirect) begin
            pc_q         <= redir_pc;
            misaligned_q <= (redirect_pc[1:0] != 2'b00);
            pred_q       <= 1'b0;
          end else if (halt_req) begin
            state_q <= StHalt;
          end else if (accept) begin
            pc_q   <= btb_hit ? btb_next : pc_plus4;
            pred_q <= btb_hit;
          end
        end
        StHalt: begin
          if (trap) begin
            state_q      <= StRun;
            pc_q         <= trap_pc;
            misaligned_q <= (trap_vec[1:0] != 2'b00);
            pred_q       <= 1'b0;
          end else if (resume) begin
            state_q <= StRun;
          end
        end
        default: state_q <= StBoot;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios with literal expectations
// followed by randomized traffic checked against a rule-level reference model.
module tb_pc_gen;

  localparam int unsigned BootDelay = 4;
  localparam int unsigned BtbDepth  = 8;
`ifdef PC_BTB_EN
  localparam bit BtbEn = 1'b1;
`else
  localparam bit BtbEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        trap = 1'b0;
  logic [31:0] trap_vec = '0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic        imem_ready = 1'b1;
  logic        btb_upd = 1'b0;
  logic [31:0] btb_src_pc = '0;
  logic [31:0] btb_tgt = '0;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic [31:0] pc_plus4;
  logic        misaligned;
  logic        pred_taken;
  logic [1:0]  state_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: 0 boot, 1 run, 2 halt.
  logic [1:0]  m_state;
  logic [31:0] m_pc;
  int          m_boot;
  bit          m_mis;
  bit          m_pred;
  bit          m_bv   [BtbDepth];
  logic [31:0] m_bsrc [BtbDepth];
  logic [31:0] m_btgt [BtbDepth];

  pc_gen #(
    .XLEN        (32),
    .RESET_VECTOR(32'h0),
    .BOOT_DELAY  (BootDelay),
    .BTB_DEPTH   (BtbDepth)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .trap       (trap),
    .trap_vec   (trap_vec),
    .halt_req   (halt_req),
    .resume     (resume),
    .imem_ready (imem_ready),
    .btb_upd    (btb_upd),
    .btb_src_pc (btb_src_pc),
    .btb_tgt    (btb_tgt),
    .pc_out     (pc_out),
    .pc_valid   (pc_valid),
    .pc_plus4   (pc_plus4),
    .misaligned (misaligned),
    .pred_taken (pred_taken),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0; trap = 1'b0; trap_vec = '0;
    halt_req = 1'b0; resume = 1'b0; imem_ready = 1'b1;
    btb_upd = 1'b0; btb_src_pc = '0; btb_tgt = '0;
  endtask

  task automatic model_reset();
    m_state = 2'd0; m_pc = 32'h0; m_boot = BootDelay; m_mis = 0; m_pred = 0;
    for (int i = 0; i < BtbDepth; i++) m_bv[i] = 0;
  endtask

  // Advance the model by one clock from the current inputs, then clock the DUT.
  task automatic tick();
    logic [31:0] npc;
    logic [1:0]  ns;
    bit          nmis, npred, hit;
    int          idx, widx;
    npc = m_pc; ns = m_state; nmis = 0; npred = m_pred;
    idx = int'((m_pc >> 2) % BtbDepth);
    hit = BtbEn && m_bv[idx] && (m_bsrc[idx] == (m_pc & ~32'h3));
    if (m_state == 2'd0) begin
      if (m_boot == 0) ns = 2'd1;
      else m_boot = m_boot - 1;
    end else if (m_state == 2'd1) begin
      if (trap) begin
        npc = trap_vec & ~32'h3; nmis = (trap_vec % 4) != 0; npred = 0;
      end else if (redirect) begin
        npc = redirect_pc & ~32'h3; nmis = (redirect_pc % 4) != 0; npred = 0;
      end else if (halt_req) begin
        ns = 2'd2;
      end else if (imem_ready && !stall) begin
        npc = hit ? m_btgt[idx] : m_pc + 32'd4;
        npred = hit;
      end
    end else begin
      if (trap) begin
        ns = 2'd1; npc = trap_vec & ~32'h3; nmis = (trap_vec % 4) != 0; npred = 0;
      end else if (resume) begin
        ns = 2'd1;
      end
    end
    if (btb_upd) begin
      widx = int'((btb_src_pc >> 2) % BtbDepth);
      m_bv[widx] = 1; m_bsrc[widx] = btb_src_pc & ~32'h3; m_btgt[widx] = btb_tgt & ~32'h3;
    end
    @(posedge clk);
    #1;
    m_state = ns; m_pc = npc; m_mis = nmis; m_pred = npred;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_boot();
    apply_reset();
    vectors++;
    if (pc_valid !== 1'b0 || state_o !== 2'd0) begin
      miscompares++;
      $display("FAIL boot_release valid/state got %b/%0d want 0/0", pc_valid, state_o);
    end
    for (int i = 1; i <= BootDelay; i++) begin
      tick();
      vectors++;
      if (pc_valid !== 1'b0 || pc_out !== 32'h0) begin
        miscompares++;
        $display("FAIL boot_wait cyc %0d valid/pc got %b/%h want 0/0", i, pc_valid, pc_out);
      end
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if (pc_valid !== 1'b1 || pc_out !== 32'(4 * k) || state_o !== 2'd1) begin
        miscompares++;
        $display("FAIL boot_seq %0d valid/pc got %b/%h want 1/%h", k, pc_valid, pc_out,
                 32'(4 * k));
      end
    end
    tick();  // 0xC accepted, pc = 0x10
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (pc_out !== 32'h10) begin
        miscompares++;
        $display("FAIL stall_hold %0d pc got %h want 00000010", i, pc_out);
      end
    end
    stall = 1'b0; imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (pc_out !== 32'h10) begin
        miscompares++;
        $display("FAIL nready_hold %0d pc got %h want 00000010", i, pc_out);
      end
    end
    imem_ready = 1'b1;
    tick();
    vectors++;
    if (pc_out !== 32'h14 || pc_plus4 !== 32'h18) begin
      miscompares++;
      $display("FAIL stall_release pc/plus4 got %h/%h want 00000014/00000018", pc_out, pc_plus4);
    end
  endtask

  task automatic test_redirect_trap();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    vectors++;
    if (pc_out !== 32'h200 || misaligned !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_stall pc/mis got %h/%b want 00000200/0", pc_out, misaligned);
    end
    imem_ready = 1'b0; redirect_pc = 32'h300; trap = 1'b1; trap_vec = 32'h80;
    tick();
    vectors++;
    if (pc_out !== 32'h80) begin
      miscompares++;
      $display("FAIL trap_over_redir pc got %h want 00000080", pc_out);
    end
    idle_inputs();
  endtask

  task automatic test_misaligned();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h203;
    tick();
    vectors++;
    if (pc_out !== 32'h200 || misaligned !== 1'b1) begin
      miscompares++;
      $display("FAIL mis_redir pc/mis got %h/%b want 00000200/1", pc_out, misaligned);
    end
    redirect = 1'b0;
    tick();
    vectors++;
    if (misaligned !== 1'b0 || pc_out !== 32'h200) begin
      miscompares++;
      $display("FAIL mis_one_cycle pc/mis got %h/%b want 00000200/0", pc_out, misaligned);
    end
    trap = 1'b1; trap_vec = 32'h81;
    tick();
    vectors++;
    if (pc_out !== 32'h80 || misaligned !== 1'b1) begin
      miscompares++;
      $display("FAIL mis_trap pc/mis got %h/%b want 00000080/1", pc_out, misaligned);
    end
    idle_inputs();
  endtask

  task automatic test_halt_wrap();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect = 1'b0; halt_req = 1'b1;
    tick();
    vectors++;
    if (state_o !== 2'd2 || pc_valid !== 1'b0 || pc_out !== 32'h20) begin
      miscompares++;
      $display("FAIL halt_enter state/valid/pc got %0d/%b/%h want 2/0/00000020", state_o,
               pc_valid, pc_out);
    end
    stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h400;
    tick();
    vectors++;
    if (state_o !== 2'd2 || pc_out !== 32'h20) begin
      miscompares++;
      $display("FAIL halt_ignore state/pc got %0d/%h want 2/00000020", state_o, pc_out);
    end
    redirect = 1'b0; halt_req = 1'b0; resume = 1'b1;
    tick();
    vectors++;
    if (state_o !== 2'd1 || pc_valid !== 1'b1 || pc_out !== 32'h20) begin
      miscompares++;
      $display("FAIL resume state/valid/pc got %0d/%b/%h want 1/1/00000020", state_o,
               pc_valid, pc_out);
    end
    resume = 1'b0; halt_req = 1'b1; stall = 1'b1;
    tick();
    halt_req = 1'b0; trap = 1'b1; trap_vec = 32'h900;
    tick();
    vectors++;
    if (state_o !== 2'd1 || pc_out !== 32'h900) begin
      miscompares++;
      $display("FAIL halt_trap state/pc got %0d/%h want 1/00000900", state_o, pc_out);
    end
    trap = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    vectors++;
    if (pc_plus4 !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_plus4 got %h want 00000000", pc_plus4);
    end
    redirect = 1'b0; stall = 1'b0;
    tick();
    vectors++;
    if (pc_out !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_pc got %h want 00000000", pc_out);
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h57;  // misaligned flag now set
    tick();
    idle_inputs();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (pc_out !== 32'h0 || state_o !== 2'd0 || pc_valid !== 1'b0 || misaligned !== 1'b0 ||
        pred_taken !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset pc/state/valid/mis/pred got %h/%0d/%b/%b/%b want 0/0/0/0/0",
               pc_out, state_o, pc_valid, misaligned, pred_taken);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    trap = 1'b1; trap_vec = 32'h80; redirect = 1'b1; redirect_pc = 32'h200; halt_req = 1'b1;
    for (int i = 0; i < BootDelay; i++) begin
      tick();
      vectors++;
      if (pc_out !== 32'h0 || state_o !== 2'd0) begin
        miscompares++;
        $display("FAIL boot_ignore %0d pc/state got %h/%0d want 0/0", i, pc_out, state_o);
      end
    end
    idle_inputs();
    tick();
    vectors++;
    if (pc_out !== 32'h0 || state_o !== 2'd1) begin
      miscompares++;
      $display("FAIL boot_exit pc/state got %h/%0d want 0/1", pc_out, state_o);
    end
  endtask

  task automatic test_btb();
    logic [31:0] exp_pc;
    exp_pc = BtbEn ? 32'h100 : 32'h44;
    stall = 1'b1; btb_upd = 1'b1; btb_src_pc = 32'h40; btb_tgt = 32'h100;
    redirect = 1'b1; redirect_pc = 32'h38;
    tick();
    idle_inputs();
    tick();  // 0x38 -> 0x3C
    tick();  // 0x3C -> 0x40
    vectors++;
    if (pc_out !== 32'h40) begin
      miscompares++;
      $display("FAIL btb_reach pc got %h want 00000040", pc_out);
    end
    tick();
    vectors++;
    if (pc_out !== exp_pc || pred_taken !== BtbEn) begin
      miscompares++;
      $display("FAIL btb_hit pc/pred got %h/%b want %h/%b", pc_out, pred_taken, exp_pc, BtbEn);
    end
    redirect = 1'b1; redirect_pc = 32'h44;
    tick();
    vectors++;
    if (pc_out !== 32'h44 || pred_taken !== 1'b0) begin
      miscompares++;
      $display("FAIL btb_redir pc/pred got %h/%b want 00000044/0", pc_out, pred_taken);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      stall       = ($urandom_range(3) == 0);
      imem_ready  = ($urandom_range(3) != 0);
      trap        = ($urandom_range(15) == 0);
      trap_vec    = $urandom_range(255);
      redirect    = ($urandom_range(7) == 0);
      redirect_pc = $urandom_range(255);
      halt_req    = ($urandom_range(15) == 0);
      resume      = ($urandom_range(3) == 0);
      btb_upd     = ($urandom_range(3) == 0);
      btb_src_pc  = $urandom_range(255);
      btb_tgt     = $urandom_range(255);
      tick();
      vectors++;
      if (pc_out !== m_pc || pc_plus4 !== m_pc + 32'd4) begin
        miscompares++;
        $display("FAIL rand_pc cyc %0d pc/plus4 got %h/%h want %h/%h", c, pc_out, pc_plus4,
                 m_pc, m_pc + 32'd4);
      end
      vectors++;
      if (state_o !== m_state || pc_valid !== (m_state == 2'd1)) begin
        miscompares++;
        $display("FAIL rand_state cyc %0d state/valid got %0d/%b want %0d/%b", c, state_o,
                 pc_valid, m_state, m_state == 2'd1);
      end
      vectors++;
      if (misaligned !== m_mis || pred_taken !== m_pred) begin
        miscompares++;
        $display("FAIL rand_flags cyc %0d mis/pred got %b/%b want %b/%b", c, misaligned,
                 pred_taken, m_mis, m_pred);
      end
    end
    idle_inputs();
  endtask

  initial begin
    #3;
    test_boot();
    test_stall();
    test_redirect_trap();
    test_misaligned();
    test_halt_wrap();
    test_reset();
    test_btb();
    apply_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
